// File: rtl/stream_merge_pkg.sv
// Shared helpers for the stream_merge slice: tag width and arbiter reset pointer.
package stream_merge_pkg;

  // Bits needed to name one of `channels` sources (at least one bit)
  function automatic int unsigned TAG_W(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Reset value of last_grant so that channel 0 is searched first
  function automatic int unsigned LAST_GRANT_RST(input int unsigned channels);
    return channels - 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Power-of-two output FIFO with show-ahead head word; full/empty derived from count.
module stream_fifo
  import stream_merge_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the pre-pop count, so a same-cycle pop never frees a slot
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stream_merge.sv
// Round-robin merge of CHANNELS input streams into one FIFO-buffered output stream.
// Define STREAM_MERGE_TAG_EN to add output_tag (source channel of the head word).
module stream_merge
  import stream_merge_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] input_data,
  input  logic [CHANNELS-1:0]       input_stb,
  output logic [CHANNELS-1:0]       input_ack,
  output logic [WIDTH-1:0]          output_data,
  output logic                      output_stb,
  input  logic                      output_ack,
  input  logic [CHANNELS-1:0]       exception_in,
  output logic [CHANNELS-1:0]       exception_src,
  output logic                      exception
`ifdef STREAM_MERGE_TAG_EN
  ,
  output logic [TAG_W(CHANNELS)-1:0] output_tag
`endif
);

  localparam int unsigned TAG_BITS = TAG_W(CHANNELS);
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
`ifdef STREAM_MERGE_TAG_EN
  localparam int unsigned ENTRY_W  = WIDTH + TAG_BITS;
`else
  localparam int unsigned ENTRY_W  = WIDTH;
`endif

  logic [TAG_BITS-1:0] last_grant;
  logic [TAG_BITS-1:0] grant_idx;
  logic [TAG_BITS-1:0] cand;
  logic                grant_vld;
  int unsigned         idx;
  logic [WIDTH-1:0]    grant_data;
  logic [ENTRY_W-1:0]  fifo_wdata;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    grant_idx = last_grant;
    grant_vld = 1'b0;
    cand      = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      cand = TAG_BITS'(idx);
      if (!grant_vld && input_stb[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (rst || fifo_full) grant_vld = 1'b0;
  end

  always_comb begin
    input_ack = '0;
    if (grant_vld) input_ack[grant_idx] = 1'b1;
  end

  assign grant_data = input_data[grant_idx*WIDTH +: WIDTH];

`ifdef STREAM_MERGE_TAG_EN
  assign fifo_wdata  = {grant_idx, grant_data};
  assign output_tag  = fifo_rdata[WIDTH +: TAG_BITS];
`else
  assign fifo_wdata  = grant_data;
`endif
  assign output_data = fifo_rdata[WIDTH-1:0];
  assign output_stb  = !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst)            last_grant <= TAG_BITS'(LAST_GRANT_RST(CHANNELS));
    else if (grant_vld) last_grant <= grant_idx;
  end

  // Sticky exception record, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) exception_src <= '0;
    else     exception_src <= exception_src | exception_in;
  end

  assign exception = |exception_src;

  stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_vld),
    .push_data (fifo_wdata),
    .pop       (output_ack),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (rst) fifo_count <= CNT_W'(DEPTH));

endmodule

// File: doc/stream_merge.md
STREAM_MERGE -- requirements
Module: stream_merge

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bits per stream word.
REQ-002 SHALL have parameter CHANNELS, default 4, range 2..16: number of input streams.
REQ-003 SHALL have parameter DEPTH, default 4, power of two, at least 2: output FIFO entries.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port input_data, input, CHANNELS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port input_stb, input, CHANNELS bits: per-channel word valid, held until acked.
REQ-008 SHALL have port input_ack, output, CHANNELS bits: per-channel one-cycle accept pulse.
REQ-009 SHALL have port output_data, output, WIDTH bits: FIFO head word.
REQ-010 SHALL have port output_stb, output, 1 bit: head word valid.
REQ-011 SHALL have port output_ack, input, 1 bit: consumer accepts head.
REQ-012 SHALL have port exception_in, input, CHANNELS bits: exception flags from the source processes.
REQ-013 SHALL have port exception_src, output, CHANNELS bits: sticky per-channel exception record.
REQ-014 SHALL have port exception, output, 1 bit: OR of exception_src.

Function
REQ-015 SHALL define full as count equal to DEPTH, evaluated before any pop in the same cycle; a simultaneous pop SHALL NOT unblock a push.
REQ-016 SHALL grant at most one channel per cycle, and only when not full.
REQ-017 SHALL search round-robin starting at last_grant+1 mod CHANNELS; last_grant SHALL update only on an actual grant.
REQ-018 SHALL drive input_ack[g] combinationally high in the grant cycle and write input_data slice g into the FIFO at that edge.
REQ-019 SHALL keep input_ack high for no more than one cycle per accepted word.
REQ-020 SHALL drive output_stb = not empty, with output_data equal to the head entry, held stable until popped.
REQ-021 SHALL pop when output_stb and output_ack are both high; the next entry SHALL appear the following cycle.
REQ-022 SHALL give a first-word latency of 1 cycle from the accept edge to output_stb high.
REQ-023 SHALL allow push and pop in the same cycle when not full, leaving count unchanged.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL hold count in clog2(DEPTH)+1 bits.
REQ-026 SHALL set exception_src[i] in the cycle after exception_in[i] is high and clear it only on reset.
REQ-027 SHALL drive exception combinationally from exception_src.
REQ-028 SHALL ensure a channel with stb low is never granted and never acked.

Reset
REQ-029 SHALL, on rst high at a clock edge, clear count, pointers, exception_src and last_grant (last_grant := CHANNELS-1, so channel 0 has first priority).
REQ-030 SHALL, during and after reset, hold output_stb=0, input_ack=0 and exception=0.
REQ-031 SHALL discard FIFO contents on reset mid-operation, and SHALL NOT ack any input in the reset cycle.

Configuration
REQ-032 SHALL, when macro STREAM_MERGE_TAG_EN is defined, add port output_tag (output, clog2(CHANNELS) bits) carrying the source channel of the head word, stored alongside the data in the FIFO.
REQ-033 SHALL, when STREAM_MERGE_TAG_EN is undefined, omit output_tag and limit FIFO storage to WIDTH bits.

Structure
REQ-034 SHALL place in shared package stream_merge_pkg: the TAG_W function (clog2 of channel count) and the reset value of last_grant.
REQ-035 SHALL implement the FIFO as sub-module stream_fifo (WIDTH and DEPTH parameters; push/pop/full/empty/count); arbitration and exception logic SHALL stay in stream_merge.

Verification
REQ-036 SHALL cover: rst, then ch1 stb with data 0xDEADBEEF and output_ack=1 -> input_ack[1] pulses one cycle; output 0xDEADBEEF with stb one cycle later; tag=1 when STREAM_MERGE_TAG_EN is defined.
REQ-037 SHALL cover: all 4 channels stb continuously, output_ack=1 -> grant order 0,1,2,3,0,...; no channel acked twice before the others.
REQ-038 SHALL cover: output_ack=0 with ch0 streaming 0x1,0x2,... -> exactly 4 acks; 5th stalled; one pop lets the 5th push one cycle later.
REQ-039 SHALL cover: exception_in[2] pulsed one cycle -> exception_src=4'b0100 and exception=1, held until rst.
REQ-040 SHALL cover: rst asserted with 3 words queued -> output_stb=0 next cycle; words lost; channel 0 wins first post-reset grant.
